chameleon_scheduler: RTL and testbench

//  Move generator for the N-chameleon ring: drives the pair-select index consumed by the game model.

---
 rtl/chameleon_pkg.sv | 11 +
 rtl/chameleon_pair_finder.sv | 42 ++++
 rtl/chameleon_scheduler.sv | 111 +++++++++++
 tb/tb_chameleon_scheduler.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/chameleon_pkg.sv
// rtl/chameleon_pkg.sv - colour encoding and scheduler state type for the chameleon ring
package chameleon_pkg;
    localparam int COLOR_W = 2;

    localparam logic [COLOR_W-1:0] RED     = 2'd0;
    localparam logic [COLOR_W-1:0] GREEN   = 2'd1;
    localparam logic [COLOR_W-1:0] BLUE    = 2'd2;
    localparam logic [COLOR_W-1:0] ILLEGAL = 2'd3;

    typedef enum logic [1:0] {SCAN, ISSUE, SETTLE, DONE} sched_state_t;
endpackage

// File: rtl/chameleon_pair_finder.sv
// rtl/chameleon_pair_finder.sv - finds the first productive pair at or after ptr, flags illegal codes
module chameleon_pair_finder
    import chameleon_pkg::*;
#(
    parameter int BITS = 2,
    localparam int N = 1 << BITS
) (
    input  logic [COLOR_W*N-1:0] colors,
    input  logic [BITS-1:0]      ptr,
    output logic                 found,
    output logic [BITS-1:0]      idx,
    output logic                 illegal
);
    // Doubling the ring lets the rotation be a plain slice with no modulo.
    logic [2*COLOR_W*N-1:0] ring2;
    logic [COLOR_W-1:0]     rot [N];
    logic [BITS-1:0]        offset;

    assign ring2 = {colors, colors};

    always_comb begin
        illegal = 1'b0;
        for (int i = 0; i < N; i++) begin
            rot[i] = ring2[COLOR_W*(int'(ptr) + i) +: COLOR_W];
            if (colors[COLOR_W*i +: COLOR_W] == ILLEGAL) illegal = 1'b1;
        end
    end

    // Descending scan so the lowest rotated offset wins.
    always_comb begin
        found  = 1'b0;
        offset = '0;
        for (int k = N - 1; k >= 0; k--) begin
            if (rot[k] != rot[(k + 1) % N]) begin
                found  = 1'b1;
                offset = BITS'(k);
            end
        end
    end

    assign idx = ptr + offset;
endmodule

// File: rtl/chameleon_scheduler.sv
// rtl/chameleon_scheduler.sv - fair round-robin move scheduler for the N-chameleon ring
module chameleon_scheduler
    import chameleon_pkg::*;
#(
    parameter int BITS      = 2,
    parameter int COUNT_W   = 8,
    parameter int MAX_MOVES = 200,
    localparam int MSB = BITS - 1,
    localparam int N   = 1 << BITS
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic [COLOR_W*N-1:0] colors,
    input  logic                 move_ready,
    input  logic                 restart,
    output logic [MSB:0]         first,
    output logic                 move_valid,
    output logic                 done,
    output logic                 abort,
    output logic                 err,
    output logic [COUNT_W-1:0]   move_count
);
    sched_state_t       state, state_n;
    logic [MSB:0]       ptr, ptr_n, first_n;
    logic               valid_n, done_n, abort_n, err_n;
    logic [COUNT_W-1:0] count_n;
    logic               found, illegal;
    logic [MSB:0]       idx;

    chameleon_pair_finder #(.BITS(BITS)) u_finder (
        .colors  (colors),
        .ptr     (ptr),
        .found   (found),
        .idx     (idx),
        .illegal (illegal)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state      <= SCAN;
            ptr        <= '0;
            first      <= '0;
            move_valid <= 1'b0;
            done       <= 1'b0;
            abort      <= 1'b0;
            err        <= 1'b0;
            move_count <= '0;
        end else begin
            state      <= state_n;
            ptr        <= ptr_n;
            first      <= first_n;
            move_valid <= valid_n;
            done       <= done_n;
            abort      <= abort_n;
            err        <= err_n;
            move_count <= count_n;
        end
    end

    always_comb begin
        state_n = state;
        ptr_n   = ptr;
        first_n = first;
        valid_n = move_valid;
        done_n  = done;
        abort_n = abort;
        err_n   = err;
        count_n = move_count;
        case (state)
            SCAN: begin
                if (illegal) begin
                    err_n   = 1'b1;
                    state_n = DONE;
                end else if (found) begin
                    first_n = idx;
                    valid_n = 1'b1;
                    state_n = ISSUE;
                end else begin
                    done_n  = 1'b1;
                    state_n = DONE;
                end
            end
            // move_valid is always high here, so move_ready alone completes the handshake.
            ISSUE: begin
                if (move_ready) begin
                    count_n = move_count + 1'b1;
                    ptr_n   = first + 1'b1;
                    valid_n = 1'b0;
                    if (count_n == COUNT_W'(MAX_MOVES)) begin
                        abort_n = 1'b1;
                        state_n = DONE;
                    end else begin
                        state_n = SETTLE;
                    end
                end
            end
            SETTLE: state_n = SCAN;
            DONE: begin
                valid_n = 1'b0;
                if (restart) begin
                    done_n  = 1'b0;
                    abort_n = 1'b0;
                    err_n   = 1'b0;
                    count_n = '0;
                    state_n = SCAN;
                end
            end
            default: state_n = SCAN;
        endcase
    end
endmodule

// File: tb/tb_chameleon_scheduler.sv
// tb/tb_chameleon_scheduler.sv - randomized self-checking bench for chameleon_scheduler
module tb_chameleon_scheduler;
    import chameleon_pkg::*;

    localparam int BITS = 2;
    localparam int N    = 1 << BITS;
    localparam int CW   = 8;

    logic            clock = 1'b0;
    logic            reset_n = 1'b0;
    logic [2*N-1:0]  colors = '0, colors_s = '0;
    logic            move_ready = 1'b0, restart = 1'b0;
    logic            ready_s = 1'b0, restart_s = 1'b0;
    logic [BITS-1:0] first, first_s;
    logic            move_valid, done, abort, err;
    logic            valid_s, done_s, abort_s, err_s;
    logic [CW-1:0]   move_count, count_s;

    int checks = 0;
    int passed = 0;
    int ptr_m = 0, count_m = 0;
    int ptr_s = 0, cnt_s = 0;

    chameleon_scheduler #(.BITS(BITS), .COUNT_W(CW), .MAX_MOVES(200)) dut (
        .clock(clock), .reset_n(reset_n), .colors(colors), .move_ready(move_ready),
        .restart(restart), .first(first), .move_valid(move_valid), .done(done),
        .abort(abort), .err(err), .move_count(move_count)
    );

    chameleon_scheduler #(.BITS(BITS), .COUNT_W(CW), .MAX_MOVES(3)) dut_small (
        .clock(clock), .reset_n(reset_n), .colors(colors_s), .move_ready(ready_s),
        .restart(restart_s), .first(first_s), .move_valid(valid_s), .done(done_s),
        .abort(abort_s), .err(err_s), .move_count(count_s)
    );

    always #5 clock = ~clock;

    function automatic logic [2*N-1:0] ring(input logic [1:0] c0, c1, c2, c3);
        return {c3, c2, c1, c0};
    endfunction

    // Reference: first i, walking from p around the ring, whose colour differs from its successor.
    function automatic int expect_first(input logic [2*N-1:0] c, input int p);
        for (int k = 0; k < N; k++) begin
            int i = (p + k) % N;
            int j = (i + 1) % N;
            if (c[2*i +: 2] != c[2*j +: 2]) return i;
        end
        return -1;
    endfunction

    function automatic logic [2*N-1:0] rand_colors();
        logic [2*N-1:0] c;
        logic [1:0] u;
        u = 2'($urandom_range(0, 2));
        for (int i = 0; i < N; i++) c[2*i +: 2] = 2'($urandom_range(0, 2));
        if ($urandom_range(0, 3) == 0) c = {N{u}};
        return c;
    endfunction

    task automatic do_reset();
        @(negedge clock);
        reset_n = 1'b0;
        @(negedge clock);
        reset_n = 1'b1;
        ptr_m = 0; count_m = 0; ptr_s = 0; cnt_s = 0;
    endtask

    task automatic wait_event();
        bit ok;
        ok = 1'b0;
        for (int t = 0; t < 20; t++) begin
            @(negedge clock);
            if (move_valid || done || err || abort) begin
                ok = 1'b1;
                break;
            end
        end
        checks++;
        if (!ok) $display("FAIL wait_event: no move_valid/done/err within 20 cycles");
        else passed++;
    endtask

    task automatic pulse_restart();
        restart = 1'b1;
        @(negedge clock);
        restart = 1'b0;
        count_m = 0;
        checks++;
        if ({done, abort, err, move_count} !== {3'b000, 8'd0})
            $display("FAIL restart_clear: done/abort/err/count=%b%b%b/%0d want 000/0", done, abort, err, move_count);
        else passed++;
    endtask

    // Holds off move_ready for 'stall' cycles while scrambling colours, then completes the handshake.
    task automatic handshake(input int exp_first, input int stall);
        for (int s = 0; s < stall; s++) begin
            move_ready = 1'b0;
            colors = 8'($urandom);
            @(negedge clock);
            checks++;
            if (move_valid !== 1'b1 || first !== BITS'(exp_first) || move_count !== CW'(count_m))
                $display("FAIL stall_hold: valid=%b first=%0d count=%0d want 1/%0d/%0d",
                         move_valid, first, move_count, exp_first, count_m);
            else passed++;
        end
        move_ready = 1'b1;
        @(negedge clock);
        move_ready = 1'b0;
        count_m++;
        ptr_m = (exp_first + 1) % N;
        checks++;
        if (move_valid !== 1'b0 || move_count !== CW'(count_m))
            $display("FAIL handshake: valid=%b count=%0d want 0/%0d", move_valid, move_count, count_m);
        else passed++;
    endtask

    task automatic test_reset();
        bit seen;
        seen = 1'b0;
        colors = ring(RED, RED, RED, RED);
        #1;
        checks++;
        if ({first, move_valid, done, abort, err, move_count} !== '0)
            $display("FAIL reset_outputs: first=%0d valid=%b done=%b abort=%b err=%b count=%0d want all 0",
                     first, move_valid, done, abort, err, move_count);
        else passed++;
        do_reset();
        for (int t = 0; t < 2; t++) begin
            @(negedge clock);
            if (move_valid) seen = 1'b1;
        end
        checks++;
        if (done !== 1'b1 || seen) $display("FAIL all_red_done: done=%b valid_seen=%b want 1/0", done, seen);
        else passed++;
    endtask

    task automatic test_basic();
        colors = ring(RED, GREEN, GREEN, GREEN);
        pulse_restart();
        wait_event();
        checks++;
        if (move_valid !== 1'b1 || first !== 2'd0) $display("FAIL basic_first0: valid=%b first=%0d want 1/0", move_valid, first);
        else passed++;
        handshake(0, 0);
        colors = ring(BLUE, BLUE, GREEN, GREEN);
        wait_event();
        checks++;
        if (move_valid !== 1'b1 || first !== 2'd1) $display("FAIL basic_first1: valid=%b first=%0d want 1/1", move_valid, first);
        else passed++;
        handshake(1, 0);
    endtask

    task automatic test_stall();
        logic [2*N-1:0] c;
        int e;
        do c = rand_colors(); while (expect_first(c, ptr_m) < 0);
        colors = c;
        e = expect_first(c, ptr_m);
        wait_event();
        checks++;
        if (move_valid !== 1'b1 || first !== BITS'(e)) $display("FAIL stall_first: valid=%b first=%0d want 1/%0d", move_valid, first, e);
        else passed++;
        handshake(e, 5);
    endtask

    task automatic test_random();
        logic [2*N-1:0] c;
        bit in_done;
        int e;
        in_done = 1'b0;
        for (int it = 0; it < 40; it++) begin
            c = rand_colors();
            colors = c;
            if (in_done) pulse_restart();
            wait_event();
            e = expect_first(c, ptr_m);
            checks++;
            if (e < 0) begin
                in_done = 1'b1;
                if (done !== 1'b1 || move_valid !== 1'b0 || err !== 1'b0)
                    $display("FAIL rand_done it=%0d colors=%b: done=%b valid=%b err=%b want 1/0/0", it, c, done, move_valid, err);
                else passed++;
            end else begin
                in_done = 1'b0;
                if (move_valid !== 1'b1 || first !== BITS'(e))
                    $display("FAIL rand_move it=%0d colors=%b ptr=%0d: valid=%b first=%0d want 1/%0d", it, c, ptr_m, move_valid, first, e);
                else passed++;
                handshake(e, $urandom_range(0, 3));
            end
        end
    endtask

    task automatic test_illegal();
        bit seen;
        seen = 1'b0;
        colors = ring(RED, RED, ILLEGAL, RED);
        do_reset();
        for (int t = 0; t < 4; t++) begin
            @(negedge clock);
            if (move_valid) seen = 1'b1;
        end
        checks++;
        if (err !== 1'b1 || done !== 1'b0 || abort !== 1'b0 || seen)
            $display("FAIL illegal: err=%b done=%b abort=%b valid_seen=%b want 1/0/0/0", err, done, abort, seen);
        else passed++;
        colors = ring(RED, RED, RED, RED);
        pulse_restart();
        wait_event();
        checks++;
        if (done !== 1'b1 || err !== 1'b0) $display("FAIL illegal_restart: done=%b err=%b want 1/0", done, err);
        else passed++;
    endtask

    task automatic test_abort();
        bit ok;
        int e;
        colors_s = ring(RED, GREEN, RED, GREEN);
        colors = ring(RED, RED, GREEN, GREEN);
        move_ready = 1'b0;
        ready_s = 1'b1;
        do_reset();
        for (int t = 0; t < 30; t++) begin
            @(negedge clock);
            if (abort_s) break;
            if (valid_s) begin
                e = expect_first(colors_s, ptr_s);
                checks++;
                if (first_s !== BITS'(e)) $display("FAIL abort_move %0d: first=%0d want %0d", cnt_s, first_s, e);
                else passed++;
                ptr_s = (e + 1) % N;
                cnt_s++;
            end
        end
        ready_s = 1'b0;
        checks++;
        if (abort_s !== 1'b1 || done_s !== 1'b0 || err_s !== 1'b0 || count_s !== CW'(cnt_s))
            $display("FAIL abort_state: abort=%b done=%b err=%b count=%0d want 1/0/0/%0d", abort_s, done_s, err_s, count_s, cnt_s);
        else passed++;
        restart_s = 1'b1;
        @(negedge clock);
        restart_s = 1'b0;
        checks++;
        if (abort_s !== 1'b0 || count_s !== 8'd0) $display("FAIL abort_restart: abort=%b count=%0d want 0/0", abort_s, count_s);
        else passed++;
        ok = 1'b0;
        for (int t = 0; t < 10; t++) begin
            @(negedge clock);
            if (valid_s) begin ok = 1'b1; break; end
        end
        e = expect_first(colors_s, ptr_s);
        checks++;
        if (!ok || first_s !== BITS'(e)) $display("FAIL abort_new_move: seen=%b first=%0d want 1/%0d", ok, first_s, e);
        else passed++;
    endtask

    task automatic test_reset_mid();
        int e;
        e = expect_first(colors, 0);
        wait_event();
        checks++;
        if (move_valid !== 1'b1 || first !== BITS'(e)) $display("FAIL mid_pre: valid=%b first=%0d want 1/%0d", move_valid, first, e);
        else passed++;
        move_ready = 1'b1;
        #1 reset_n = 1'b0;
        #1;
        checks++;
        if (move_valid !== 1'b0 || first !== 2'd0 || move_count !== 8'd0)
            $display("FAIL mid_async: valid=%b first=%0d count=%0d want 0/0/0", move_valid, first, move_count);
        else passed++;
        @(negedge clock);
        reset_n = 1'b1;
        move_ready = 1'b0;
        wait_event();
        checks++;
        if (move_valid !== 1'b1 || first !== BITS'(e) || move_count !== 8'd0)
            $display("FAIL mid_after: valid=%b first=%0d count=%0d want 1/%0d/0", move_valid, first, move_count, e);
        else passed++;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_stall();
        test_random();
        test_illegal();
        test_abort();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
